// File: rtl/letter_pulse_replay.sv
// Replays a 5-bit letter code as a train of single-cycle count pulses, one per unit of value.
// Optional REPLAY_REMAIN_EN adds remaining_out (pulses still to emit, nonzero only in PULSE).
module letter_pulse_replay #(
  parameter int unsigned GAP_CYCLES = 1,
  parameter logic [4:0]  MAX_VAL    = 5'd26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_button,
  input  logic [4:0] letter_val_in,
  output logic       count_pulse_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       err_out
`ifdef REPLAY_REMAIN_EN
  ,
  output logic [4:0] remaining_out
`endif
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [4:0] remaining_q, remaining_d;
  logic [7:0] gap_q, gap_d;
  logic       err_d;
  logic       pulse_q, busy_q, done_q, err_q;
  logic [4:0] rem_out_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_button) begin
          if (letter_val_in > MAX_VAL) begin
            err_d = 1'b1;
          end else if (letter_val_in == 5'd0) begin
            state_d = DONE;
          end else begin
            remaining_d = letter_val_in;
            state_d     = PULSE;
          end
        end
      end
      PULSE: begin
        remaining_d = remaining_q - 5'd1;
        if (remaining_q == 5'd1) begin
          state_d = DONE;
        end else if (GAP_CYCLES == 0) begin
          state_d = PULSE;
        end else begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          state_d = PULSE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rem_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      pulse_q     <= (state_d == PULSE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      err_q       <= err_d;
      rem_out_q   <= (state_d == PULSE) ? remaining_d : 5'd0;
    end
  end

  assign count_pulse_out = pulse_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign err_out         = err_q;

`ifdef REPLAY_REMAIN_EN
  assign remaining_out = rem_out_q;
`else
  logic unused_rem;
  assign unused_rem = ^rem_out_q;
`endif

endmodule

// File: tb/tb_letter_pulse_replay.sv
// Scoreboard bench for letter_pulse_replay: one instance with GAP_CYCLES=1, one with GAP_CYCLES=0.
module tb_letter_pulse_replay;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, start0;
  logic [4:0] val1, val0;
  logic       pulse1, busy1, done1, err1;
  logic       pulse0, busy0, done0, err0;
`ifdef REPLAY_REMAIN_EN
  logic [4:0] rem1, rem0;
`endif

  letter_pulse_replay #(.GAP_CYCLES(1), .MAX_VAL(5'd26)) u_dut1 (
    .clk(clk), .rst(rst), .start_button(start1), .letter_val_in(val1),
    .count_pulse_out(pulse1), .busy_out(busy1), .done_out(done1), .err_out(err1)
`ifdef REPLAY_REMAIN_EN
    , .remaining_out(rem1)
`endif
  );

  letter_pulse_replay #(.GAP_CYCLES(0), .MAX_VAL(5'd26)) u_dut0 (
    .clk(clk), .rst(rst), .start_button(start0), .letter_val_in(val0),
    .count_pulse_out(pulse0), .busy_out(busy0), .done_out(done0), .err_out(err0)
`ifdef REPLAY_REMAIN_EN
    , .remaining_out(rem0)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Companion letter counter driven by dut1's pulses (loop-back).
  int cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 0;
    else if (pulse1) cnt <= (cnt == 26) ? 0 : cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;  // 0 pulse, 1 done, 2 err
    int cyc;
  } ev_t;
  ev_t q1[$];
  ev_t q0[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int id, input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    if (id == 1) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic pop_check(input int id, input int kind);
    ev_t   e;
    string nm;
    int    sz;
    nm = $sformatf("dut%0d_%s", id, (kind == 0) ? "pulse" : (kind == 1) ? "done" : "err");
    sz = (id == 1) ? q1.size() : q0.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at cycle %0d, none expected", nm, cyc);
    end else begin
      if (id == 1) e = q1.pop_front();
      else e = q0.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      check({nm, "_cycle"}, cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (pulse1) pop_check(1, 0);
      if (done1)  pop_check(1, 1);
      if (err1)   pop_check(1, 2);
      if (pulse0) pop_check(0, 0);
      if (done0)  pop_check(0, 1);
      if (err0)   pop_check(0, 2);
    end
  end

  // Expected events for a replay accepted so that its first output cycle is acc; lim caps pushed pulses.
  task automatic push_replay(input int id, input int v, input int acc, input int lim);
    int g;
    g = (id == 1) ? 1 : 0;
    if (v > 26) begin
      push(id, 2, acc);
    end else if (v == 0) begin
      push(id, 1, acc);
    end else begin
      for (int k = 0; k < v && k < lim; k++) push(id, 0, acc + k * (g + 1));
      if (lim >= v) push(id, 1, acc + (v - 1) * (g + 1) + 1);
    end
  endtask

  task automatic start_replay(input int id, input int v, input int lim, output int acc);
    @(negedge clk);
    if (id == 1) begin start1 = 1'b1; val1 = 5'(v); end
    else begin start0 = 1'b1; val0 = 5'(v); end
    acc = cyc + 1;
    push_replay(id, v, acc, lim);
    @(negedge clk);
    if (id == 1) start1 = 1'b0;
    else start0 = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int budget);
    int n;
    n = 0;
    while (((id == 1) ? busy1 : busy0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d_idle_in_budget", id), (id == 1) ? busy1 : busy0, 0);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    rst = 1'b0; start1 = 1'b0; start0 = 1'b0; val1 = '0; val0 = '0;
    repeat (2) @(negedge clk);
    check("rst_pulse1", pulse1, 0);
    check("rst_busy1",  busy1,  0);
    check("rst_done1",  done1,  0);
    check("rst_err1",   err1,   0);
    check("rst_busy0",  busy0,  0);
    rst = 1'b1;
    @(negedge clk);

    // Loop-back: value 5, gap 1 -> counter reads 5, idle 10 cycles after first pulse.
    start_replay(1, 5, 99, acc);
    wait_idle(1, 40);
    check("t1_idle_cycle", cyc, acc + 10);
    check("t1_counter", cnt, 5);

    // Value 26 back-to-back, then value 0.
    start_replay(0, 26, 99, acc);
    wait_idle(0, 60);
    check("t2_26_idle_cycle", cyc, acc + 27);
    start_replay(0, 0, 99, acc);
    wait_idle(0, 10);
    check("t2_0_idle_cycle", cyc, acc + 1);

    // Rejected codes.
    start_replay(1, 27, 99, acc);
    check("t3_27_busy", busy1, 0);
    @(negedge clk);
    check("t3_27_err_single", err1, 0);
    start_replay(1, 31, 99, acc);
    check("t3_31_busy", busy1, 0);
    start_replay(0, 27, 99, acc);
    check("t3_27_busy0", busy0, 0);
    @(negedge clk);

    // Start pulsed while busy with a different value is ignored.
    start_replay(1, 7, 99, acc);
    wait_cyc(acc + 3);
    start1 = 1'b1; val1 = 5'd2;
    repeat (2) @(negedge clk);
    start1 = 1'b0;
    wait_idle(1, 40);
    check("t5_idle_cycle", cyc, acc + 14);

    // Held start re-triggers on the first idle cycle.
    @(negedge clk);
    start0 = 1'b1; val0 = 5'd2;
    acc = cyc + 1;
    push_replay(0, 2, acc, 99);
    push_replay(0, 2, acc + 4, 99);
    wait_cyc(acc + 4);
    start0 = 1'b0;
    wait_idle(0, 20);
    check("retrig_idle_cycle", cyc, acc + 7);

`ifdef REPLAY_REMAIN_EN
    begin
      logic [4:0] exp_rem [6];
      exp_rem = '{5'd3, 5'd0, 5'd2, 5'd0, 5'd1, 5'd0};
      start_replay(1, 3, 99, acc);
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t6_rem_%0d", i), rem1, exp_rem[i]);
        @(negedge clk);
      end
      wait_idle(1, 20);
    end
`endif

    // Asynchronous reset mid-GAP after 3 of 10 pulses.
    start_replay(1, 10, 3, acc);
    wait_cyc(acc + 5);
    #2 rst = 1'b0;
    #1;
    check("t4_pulse", pulse1, 0);
    check("t4_busy",  busy1,  0);
    check("t4_done",  done1,  0);
    check("t4_err",   err1,   0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_busy_after", busy1, 0);

    check("q1_drained", q1.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
